// File: rtl/fios_result_normalizer.sv
// Normalizes a stream of 34-bit redundant DSP words into 17-bit limbs by
// carry propagation, buffering the limbs in a small first-word-fall-through FIFO.
module fios_result_normalizer #(
  parameter int LIMB_COUNT = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        P_valid_i,
  input  logic [33:0] P_i,
  output logic        P_ready_o,
  output logic [16:0] limb_o,
  output logic        limb_valid_o,
  input  logic        limb_ready_i,
  output logic        limb_last_o,
  output logic [17:0] carry_o,
  output logic        done_o,
  output logic        busy_o
);

  localparam int CNT_W = $clog2(LIMB_COUNT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [17:0]        r_carry_q;
  logic [17:0]        r_carry_out;
  logic               r_done;
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;
  logic [17:0]        r_mem [FIFO_DEPTH];

  logic [34:0]        w_sum;
  logic               w_last_word;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_pop_last;
  logic [17:0]        w_head;

  // Full carry-save sum: 34-bit word plus an 18-bit carry never overflows 35 bits.
  assign w_sum       = {1'b0, P_i} + {17'b0, r_carry_q};
  assign w_last_word = (r_count == CNT_W'(LIMB_COUNT - 1));

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr == {~r_rd_ptr[PTR_W], r_rd_ptr[PTR_W-1:0]});
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign P_ready_o    = (r_state == ST_ACCUM) && !w_full;
  assign limb_valid_o = !w_empty;
  assign limb_o       = w_empty ? 17'd0 : w_head[17:1];
  assign limb_last_o  = w_empty ? 1'b0  : w_head[0];
  assign carry_o      = r_carry_out;
  assign done_o       = r_done;
  assign busy_o       = (r_state != ST_IDLE);

  assign w_push     = P_valid_i && P_ready_o;
  assign w_pop      = limb_valid_o && limb_ready_i;
  assign w_pop_last = w_pop && w_head[0];

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state; otherwise a latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (start_i)                   w_state_next = ST_ACCUM;
      ST_ACCUM: if (w_push && w_last_word)     w_state_next = ST_FLUSH;
      ST_FLUSH: if (w_pop_last)                w_state_next = ST_IDLE;
      default:                                 w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_count     <= '0;
      r_carry_q   <= '0;
      r_carry_out <= '0;
      r_done      <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_done <= w_pop_last;

      if ((r_state == ST_IDLE) && start_i) begin
        r_count     <= '0;
        r_carry_q   <= '0;
        r_carry_out <= '0;
      end

      if (w_push) begin
        r_carry_q <= w_sum[34:17];
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        if (w_last_word) begin
          r_count     <= '0;
          r_carry_out <= w_sum[34:17];
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // NOTE: storage is not reset; emptied pointers and gated outputs hide stale contents.
  always_ff @(posedge clock_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {w_sum[16:0], w_last_word};
    end
  end

endmodule

// File: tb/tb_fios_result_normalizer.sv
// Randomized bench: each result is checked against the base-2^17 digits of the
// weighted word sum, with buffer occupancy tracked to predict handshakes.
module tb_fios_result_normalizer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        p_valid;
  logic [33:0] p_data;
  logic        limb_ready;
  logic        sel;

  logic        rdy4, rdy6, lv4, lv6, ll4, ll6, dn4, dn6, bz4, bz6;
  logic [16:0] lb4, lb6;
  logic [17:0] cy4, cy6;

  logic        o_p_ready, o_limb_valid, o_limb_last, o_done, o_busy;
  logic [16:0] o_limb;
  logic [17:0] o_carry;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] w_words [8];

  always #5 clk = ~clk;

  fios_result_normalizer #(.LIMB_COUNT(4), .FIFO_DEPTH(DEPTH)) u_dut4 (
    .clock_i(clk), .reset_i(rst), .start_i(start && !sel),
    .P_valid_i(p_valid && !sel), .P_i(p_data), .P_ready_o(rdy4),
    .limb_o(lb4), .limb_valid_o(lv4), .limb_ready_i(limb_ready && !sel),
    .limb_last_o(ll4), .carry_o(cy4), .done_o(dn4), .busy_o(bz4)
  );

  fios_result_normalizer #(.LIMB_COUNT(6), .FIFO_DEPTH(DEPTH)) u_dut6 (
    .clock_i(clk), .reset_i(rst), .start_i(start && sel),
    .P_valid_i(p_valid && sel), .P_i(p_data), .P_ready_o(rdy6),
    .limb_o(lb6), .limb_valid_o(lv6), .limb_ready_i(limb_ready && sel),
    .limb_last_o(ll6), .carry_o(cy6), .done_o(dn6), .busy_o(bz6)
  );

  assign o_p_ready    = sel ? rdy6 : rdy4;
  assign o_limb       = sel ? lb6  : lb4;
  assign o_limb_valid = sel ? lv6  : lv4;
  assign o_limb_last  = sel ? ll6  : ll4;
  assign o_carry      = sel ? cy6  : cy4;
  assign o_done       = sel ? dn6  : dn4;
  assign o_busy       = sel ? bz6  : bz4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [33:0] rand_word();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0:       return 34'd0;
      1:       return 34'h3_FFFF_FFFF;
      default: return r[33:0];
    endcase
  endfunction

  // Runs one whole result on the selected instance (lc = 4 or 6) using w_words.
  task automatic run_result(input string name, input int lc, input int valid_pct,
                            input int ready_pct, input bit use_sched,
                            input logic [63:0] sched);
    logic [255:0] total, shifted;
    logic [16:0]  exp_limb [8];
    logic [17:0]  exp_carry;
    logic [63:0]  rnd;
    int acc, pops, occ, cyc;
    bit prev_stall, prev_pop_last, push, pop, finished;
    logic [16:0] prev_limb;

    total = '0;
    for (int i = 0; i < lc; i++) total = total + (256'(w_words[i]) << (17 * i));
    for (int i = 0; i < lc; i++) exp_limb[i] = total[17*i +: 17];
    shifted   = total >> (17 * lc);
    exp_carry = shifted[17:0];

    sel        = (lc == 6);
    start      = 1'b1;
    p_valid    = ($urandom_range(0, 1) == 1);
    rnd        = {$urandom, $urandom};
    p_data     = rnd[33:0];
    limb_ready = 1'b0;
    step();

    acc = 0; pops = 0; occ = 0;
    prev_stall = 0; prev_pop_last = 0; prev_limb = '0; finished = 0;
    for (cyc = 0; cyc < 400 && !finished; cyc++) begin
      start   = ($urandom_range(0, 3) == 0);
      p_valid = ($urandom_range(1, 100) <= valid_pct);
      rnd     = {$urandom, $urandom};
      p_data  = (p_valid && acc < lc) ? w_words[acc] : rnd[33:0];
      if (use_sched) limb_ready = (cyc < 64) ? sched[cyc] : 1'b1;
      else           limb_ready = ($urandom_range(1, 100) <= ready_pct);

      check({name, ".done"},    64'(o_done),       64'(prev_pop_last));
      check({name, ".p_ready"}, 64'(o_p_ready),    64'((acc < lc) && (occ < DEPTH)));
      check({name, ".valid"},   64'(o_limb_valid), 64'(occ > 0));
      if (prev_stall) check({name, ".stable"}, 64'(o_limb), 64'(prev_limb));

      if (prev_pop_last) begin
        start = 1'b0;
        check({name, ".carry"}, 64'(o_carry), 64'(exp_carry));
        check({name, ".busy"},  64'(o_busy),  64'(0));
        finished = 1;
      end else begin
        push = p_valid && o_p_ready;
        pop  = o_limb_valid && limb_ready;
        prev_pop_last = 0;
        if (pop) begin
          if (pops < lc) check({name, ".limb"}, 64'(o_limb), 64'(exp_limb[pops]));
          check({name, ".last"}, 64'(o_limb_last), 64'(pops == lc - 1));
          pops++;
          prev_pop_last = (pops == lc);
        end
        prev_stall = o_limb_valid && !limb_ready;
        prev_limb  = o_limb;
        occ = occ + int'(push) - int'(pop);
        acc = acc + int'(push);
        step();
      end
    end
    if (!finished) check({name, ".timeout"}, 64'(0), 64'(1));

    p_valid = 1'b0; limb_ready = 1'b0; start = 1'b0;
    step();
    check({name, ".done_once"}, 64'(o_done),  64'(0));
    check({name, ".carry_hold"}, 64'(o_carry), 64'(exp_carry));
  endtask

  initial begin
    logic [17:0] held;
    sel = 1'b0; rst = 1'b1; start = 1'b1; p_valid = 1'b1;
    p_data = 34'h1_2345_6789; limb_ready = 1'b1;
    step();
    step();
    check("rst.p_ready", 64'(o_p_ready),    64'(0));
    check("rst.valid",   64'(o_limb_valid), 64'(0));
    check("rst.limb",    64'(o_limb),       64'(0));
    check("rst.last",    64'(o_limb_last),  64'(0));
    check("rst.carry",   64'(o_carry),      64'(0));
    check("rst.done",    64'(o_done),       64'(0));
    check("rst.busy",    64'(o_busy),       64'(0));
    rst = 1'b0; start = 1'b0; p_valid = 1'b0; limb_ready = 1'b0;
    step();

    for (int i = 0; i < 4; i++) w_words[i] = 34'h3_FFFF_FFFF;
    run_result("chain", 4, 100, 100, 1'b0, 64'd0);
    check("chain.carry_val", 64'(o_carry), 64'h20000);

    w_words[0] = 34'h20005; w_words[1] = 34'd3; w_words[2] = 34'd0; w_words[3] = 34'd0;
    run_result("small", 4, 100, 100, 1'b0, 64'd0);

    held = o_carry;
    p_valid = 1'b1; limb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p_data = rand_word();
      step();
      check("idle.p_ready", 64'(o_p_ready),    64'(0));
      check("idle.valid",   64'(o_limb_valid), 64'(0));
      check("idle.busy",    64'(o_busy),       64'(0));
      check("idle.carry",   64'(o_carry),      64'(held));
    end
    p_valid = 1'b0; limb_ready = 1'b0;

    for (int i = 0; i < 6; i++) w_words[i] = rand_word();
    run_result("bp6", 6, 100, 0, 1'b1, 64'hFFFF_FFFF_FFFF_F100);

    sel = 1'b0; start = 1'b1;
    step();
    start = 1'b0; p_valid = 1'b1; p_data = 34'h3_FFFF_FFFF;
    check("mid.p_ready", 64'(o_p_ready), 64'(1));
    step();
    p_data = 34'h3_FFFF_FFFF;
    step();
    p_valid = 1'b0; rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("mid.valid", 64'(o_limb_valid), 64'(0));
    check("mid.busy",  64'(o_busy),       64'(0));
    check("mid.carry", 64'(o_carry),      64'(0));
    w_words[0] = 34'd1; w_words[1] = 34'd2; w_words[2] = 34'd3; w_words[3] = 34'd4;
    run_result("after_rst", 4, 100, 100, 1'b0, 64'd0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) w_words[i] = rand_word();
      run_result("rand4", 4, 60, 50, 1'b0, 64'd0);
    end
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 6; i++) w_words[i] = rand_word();
      run_result("rand6", 6, 70, 30, 1'b0, 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
